// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: issues one aligned 64-bit bus transaction per
// access, builds store masks/shifted data and returns the raw load word.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        memdata_width,
  input  logic              mem_advance,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_wen,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  output logic [7:0]        req_wmask,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_rdata,
  output logic [DATA_W-1:0] rw_rdata,
  output logic [2:0]        res_off,
  output logic              mem_stall,
  output logic              misalign
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] off;
  logic [2:0] size_m1;
  logic [7:0] base_mask;
  logic       access;
  logic       misaligned;
  logic       capture;

  assign off = mem_addr[2:0];

  // Lane mask for the access size before shifting to the byte offset.
  always_comb begin
    base_mask = '0;
    size_m1   = 3'd0;
    case (memdata_width)
      3'b001: begin
        base_mask = 8'hFF;
        size_m1   = 3'd7;
      end
      3'b010, 3'b101: begin
        base_mask = 8'h0F;
        size_m1   = 3'd3;
      end
      3'b011, 3'b110: begin
        base_mask = 8'h03;
        size_m1   = 3'd1;
      end
      3'b100, 3'b111: begin
        base_mask = 8'h01;
        size_m1   = 3'd0;
      end
      default: begin
        base_mask = '0;
        size_m1   = 3'd0;
      end
    endcase
  end

  assign access     = (mem_re | mem_we) && (memdata_width != 3'b000);
  assign misaligned = (off & size_m1) != 3'b000;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    req_valid = 1'b0;
    misalign  = 1'b0;
    mem_stall = access && (state != DONE) && (state != FAULT);
    case (state)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            state_nxt = FAULT;
          end else begin
            state_nxt = REQ;
            capture   = 1'b1;
          end
        end
      end
      REQ: begin
        req_valid = 1'b1;
        if (req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (resp_valid) state_nxt = DONE;
      end
      // Held here until the pipeline advances so a stalled stage cannot re-issue.
      DONE: begin
        if (mem_advance) state_nxt = IDLE;
      end
      FAULT: begin
        misalign  = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_wen   <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wmask <= '0;
      res_off   <= '0;
      rw_rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        req_wen   <= mem_we;
        req_addr  <= {mem_addr[ADDR_W-1:3], 3'b000};
        req_wdata <= mem_wdata << {off, 3'b000};
        req_wmask <= base_mask << off;
        res_off   <= off;
      end
      if ((state == WAIT) && resp_valid && !req_wen) rw_rdata <= resp_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of single transactions plus
// hand-written sequences for back-pressure, DONE hold, no-access and reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_re, mem_we, mem_advance;
  logic [63:0] mem_addr, mem_wdata;
  logic [2:0]  memdata_width;
  logic        req_valid, req_ready, req_wen;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic [63:0] resp_rdata, rw_rdata;
  logic [2:0]  res_off;
  logic        mem_stall, misalign;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_rw;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .memdata_width(memdata_width), .mem_advance(mem_advance),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .rw_rdata(rw_rdata), .res_off(res_off), .mem_stall(mem_stall), .misalign(misalign)
  );

  typedef struct {
    logic        re;
    logic        we;
    logic [2:0]  width;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [63:0] e_addr;
    logic [63:0] e_wdata;
    logic [7:0]  e_mask;
    logic [2:0]  e_off;
    logic        e_mis;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_re = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    memdata_width = 3'b000; mem_advance = 1'b0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    @(negedge clk);
    mem_re = v.re; mem_we = v.we; memdata_width = v.width;
    mem_addr = v.addr; mem_wdata = v.wdata;
    req_ready = 1'b1; resp_valid = 1'b0; mem_advance = 1'b0;
    #1;
    chk({s, "_idle_stall"}, mem_stall, 1);
    chk({s, "_idle_valid"}, req_valid, 0);
    if (v.e_mis) begin
      @(negedge clk); #1;
      chk({s, "_fault_misalign"}, misalign, 1);
      chk({s, "_fault_valid"}, req_valid, 0);
      chk({s, "_fault_stall"}, mem_stall, 0);
      @(negedge clk); mem_advance = 1'b1; #1;
      chk({s, "_done_misalign"}, misalign, 0);
      chk({s, "_done_valid"}, req_valid, 0);
      chk({s, "_done_stall"}, mem_stall, 0);
    end else begin
      @(negedge clk); #1;
      chk({s, "_req_valid"}, req_valid, 1);
      chk({s, "_req_addr"}, req_addr, v.e_addr);
      chk({s, "_req_wdata"}, req_wdata, v.e_wdata);
      chk({s, "_req_wmask"}, req_wmask, v.e_mask);
      chk({s, "_req_wen"}, req_wen, v.we);
      chk({s, "_res_off"}, res_off, v.e_off);
      @(negedge clk); resp_valid = 1'b1; resp_rdata = v.rdata; #1;
      chk({s, "_wait_valid"}, req_valid, 0);
      chk({s, "_wait_stall"}, mem_stall, 1);
      @(negedge clk); resp_valid = 1'b0; mem_advance = 1'b1; #1;
      if (!v.we) exp_rw = v.rdata;
      chk({s, "_done_stall"}, mem_stall, 0);
      chk({s, "_rw_rdata"}, rw_rdata, exp_rw);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_cycles;
    //            re    we    width   addr     wdata                  rdata                  e_addr   e_wdata                e_mask e_off e_mis
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 64'h1004, 64'h0,                 64'h1122334455667788, 64'h1000, 64'h0,                 8'hF0, 3'd4, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 3'b100, 64'h2003, 64'hAB,                64'h0,                64'h2000, 64'h00000000AB000000, 8'h08, 3'd3, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 3'b011, 64'h10A6, 64'hBEEF,              64'h0,                64'h10A0, 64'hBEEF000000000000, 8'hC0, 3'd6, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 3'b001, 64'h3000, 64'h0123456789ABCDEF,  64'h0,                64'h3000, 64'h0123456789ABCDEF, 8'hFF, 3'd0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b111, 64'h5005, 64'h11,                64'hCAFEF00DDEADBEEF, 64'h5000, 64'h0000110000000000, 8'h20, 3'd5, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'b110, 64'h6002, 64'h0,                 64'h0A0B0C0D0E0F1011, 64'h6000, 64'h0,                 8'h0C, 3'd2, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 3'b101, 64'h7000, 64'h89ABCDEF,          64'h0,                64'h7000, 64'h0000000089ABCDEF, 8'h0F, 3'd0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3'b011, 64'h4007, 64'h0,                 64'h0,                64'h0,    64'h0,                 8'h00, 3'd0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 64'h8002, 64'h0,                 64'h0,                64'h0,    64'h0,                 8'h00, 3'd0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 3'b001, 64'h9004, 64'h0,                 64'h0,                64'h0,    64'h0,                 8'h00, 3'd0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 3'b010, 64'h400C, 64'h12345678,          64'h0,                64'h4008, 64'h1234567800000000, 8'hF0, 3'd4, 1'b0};

    clear_inputs();
    exp_rw = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_wen", req_wen, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_req_wdata", req_wdata, 0);
    chk("rst_req_wmask", req_wmask, 0);
    chk("rst_rw_rdata", rw_rdata, 0);
    chk("rst_res_off", res_off, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_misalign", misalign, 0);
    rst = 1'b0;

    // Load W with a two-cycle response: stall for IDLE, REQ, WAIT, WAIT.
    stall_cycles = 0;
    @(negedge clk);
    mem_re = 1'b1; memdata_width = 3'b010; mem_addr = 64'h1004; req_ready = 1'b1; #1;
    if (mem_stall) stall_cycles++;
    @(negedge clk); #1;
    if (mem_stall) stall_cycles++;
    chk("a_req_addr", req_addr, 64'h1000);
    chk("a_req_wmask", req_wmask, 8'hF0);
    chk("a_req_wen", req_wen, 0);
    @(negedge clk); #1;
    if (mem_stall) stall_cycles++;
    @(negedge clk); resp_valid = 1'b1; resp_rdata = 64'h1122334455667788; #1;
    if (mem_stall) stall_cycles++;
    @(negedge clk); resp_valid = 1'b0; mem_advance = 1'b1; #1;
    if (mem_stall) stall_cycles++;
    exp_rw = 64'h1122334455667788;
    chk("a_stall_cycles", stall_cycles, 4);
    chk("a_rw_rdata", rw_rdata, exp_rw);
    chk("a_res_off", res_off, 3'd4);
    @(negedge clk); clear_inputs();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Store DW with 3 cycles of back-pressure; resp_valid during REQ is ignored.
    @(negedge clk);
    mem_we = 1'b1; memdata_width = 3'b001; mem_addr = 64'h3000; mem_wdata = 64'hDEADBEEF01234567;
    req_ready = 1'b0; #1;
    chk("b_idle_stall", mem_stall, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_ready  = (i == 3);
      resp_valid = (i < 3);
      resp_rdata = 64'h5555AAAA5555AAAA;
      #1;
      chk($sformatf("b_valid_%0d", i), req_valid, 1);
      chk($sformatf("b_addr_%0d", i), req_addr, 64'h3000);
      chk($sformatf("b_wdata_%0d", i), req_wdata, 64'hDEADBEEF01234567);
      chk($sformatf("b_wmask_%0d", i), req_wmask, 8'hFF);
      chk($sformatf("b_wen_%0d", i), req_wen, 1);
    end
    @(negedge clk); req_ready = 1'b0; resp_valid = 1'b0; #1;
    chk("b_wait_valid", req_valid, 0);
    chk("b_wait_stall", mem_stall, 1);
    @(negedge clk); resp_valid = 1'b1; #1;
    chk("b_wait2_stall", mem_stall, 1);
    @(negedge clk); resp_valid = 1'b0; mem_advance = 1'b1; #1;
    chk("b_done_stall", mem_stall, 0);
    chk("b_rw_unchanged", rw_rdata, exp_rw);
    @(negedge clk); clear_inputs();

    // Load finishes while the pipeline holds for two cycles.
    @(negedge clk);
    mem_re = 1'b1; memdata_width = 3'b100; mem_addr = 64'h0005; req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); resp_valid = 1'b1; resp_rdata = 64'h7766554433221100;
    exp_rw = 64'h7766554433221100;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); resp_valid = 1'b0; mem_advance = 1'b0; #1;
      chk($sformatf("c_hold_valid_%0d", i), req_valid, 0);
      chk($sformatf("c_hold_stall_%0d", i), mem_stall, 0);
    end
    chk("c_rw_rdata", rw_rdata, exp_rw);
    @(negedge clk); mem_advance = 1'b1; #1;
    chk("c_adv_valid", req_valid, 0);
    chk("c_adv_stall", mem_stall, 0);
    @(negedge clk); mem_advance = 1'b0; #1;
    chk("c_idle_stall", mem_stall, 1);
    chk("c_idle_valid", req_valid, 0);
    mem_re = 1'b0; #1;
    chk("c_idle_nostall", mem_stall, 0);
    @(negedge clk); clear_inputs();

    // Width 000 never starts an access.
    @(negedge clk);
    mem_re = 1'b1; mem_we = 1'b1; memdata_width = 3'b000; mem_addr = 64'h1234; req_ready = 1'b1; #1;
    chk("d_stall", mem_stall, 0);
    @(negedge clk); #1;
    chk("d_valid", req_valid, 0);
    chk("d_misalign", misalign, 0);
    @(negedge clk); clear_inputs();

    // Reset while waiting for a response, then a late response.
    @(negedge clk);
    mem_re = 1'b1; memdata_width = 3'b001; mem_addr = 64'h1008; req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("e_wait_stall", mem_stall, 1);
    rst = 1'b1; clear_inputs(); #1;
    exp_rw = '0;
    chk("e_rst_valid", req_valid, 0);
    chk("e_rst_addr", req_addr, 0);
    chk("e_rst_wmask", req_wmask, 0);
    chk("e_rst_rw", rw_rdata, exp_rw);
    chk("e_rst_off", res_off, 0);
    chk("e_rst_stall", mem_stall, 0);
    @(negedge clk); rst = 1'b0; resp_valid = 1'b1; resp_rdata = 64'hFFFFFFFFFFFFFFFF;
    @(negedge clk); resp_valid = 1'b0; #1;
    chk("e_late_rw", rw_rdata, exp_rw);
    chk("e_late_valid", req_valid, 0);
    chk("e_late_stall", mem_stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
